add_scheduler: RTL

Round-robin scheduler that shares one multi-cycle `add` unit (start/complete handshake, DATA_WIDTH operands) among NUM_REQ requesters. It arbitrates requests, latches the winner's operands, sequences the adder's start pulse, waits for completion with a watchdog, and returns the sum to the winning requester. It sits between the requesting datapath blocks and the single shared adder instance.

---
 rtl/add_sched_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 24 ++
 rtl/add_scheduler.sv | 102 ++++++++++
 3 files changed

// File: rtl/add_sched_pkg.sv
// rtl/add_sched_pkg.sv - shared state encoding for the add scheduler
package add_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  // Walk offsets from farthest to nearest so the first requester after ptr wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/add_scheduler.sv
// rtl/add_scheduler.sv - shares one multi-cycle adder among NUM_REQ requesters
module add_scheduler
  import add_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] op_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] op_b,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         result,
  output logic                          error,
  output logic                          add_start,
  output logic [DATA_WIDTH-1:0]         add_addend1,
  output logic [DATA_WIDTH-1:0]         add_addend2,
  input  logic [DATA_WIDTH-1:0]         add_sum,
  input  logic                          add_complete
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  sched_state_t     state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic [CNT_W-1:0] cnt;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req         (req),
    .ptr         (ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Pulse outputs default low every cycle; each state raises only what it owns.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      winner      <= '0;
      cnt         <= '0;
      ack         <= '0;
      done        <= '0;
      result      <= '0;
      error       <= 1'b0;
      add_start   <= 1'b0;
      add_addend1 <= '0;
      add_addend2 <= '0;
    end else begin
      ack       <= '0;
      done      <= '0;
      result    <= '0;
      error     <= 1'b0;
      add_start <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            winner      <= grant_idx;
            add_addend1 <= op_a[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            add_addend2 <= op_b[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            ack         <= NUM_REQ'(1) << grant_idx;
            add_start   <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (add_complete) begin
            result <= add_sum;
            done   <= NUM_REQ'(1) << winner;
            state  <= RESPOND;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            error <= 1'b1;
            done  <= NUM_REQ'(1) << winner;
            state <= RESPOND;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESPOND: begin
          ptr   <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
